// File: rtl/cam_dvp_emulator_if.sv
// DVP camera bus: pixel clock, frame/line syncs and the 8-bit byte stream.
interface cam_dvp_emulator_if;
  logic       CAM_pclk;
  logic       CAM_vsync;
  logic       CAM_href;
  logic [7:0] CAM_px_data;

  modport master (output CAM_pclk, CAM_vsync, CAM_href, CAM_px_data);
  modport slave  (input  CAM_pclk, CAM_vsync, CAM_href, CAM_px_data);
endinterface

// File: rtl/cam_dvp_emulator.sv
// OV7670-style DVP source: emits RGB565 test patterns as a byte stream with
// VSYNC/HREF framing on a pixel clock running at clk/2.
module cam_dvp_emulator #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int H_BLANK  = 144,
  parameter int VS_PCLKS = 1568,
  parameter int V_PORCH  = 784
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [1:0]                pattern,
  input  logic [15:0]               solid_rgb565,
  cam_dvp_emulator_if.master        cam,
  output logic                      frame_done,
  output logic [7:0]                frame_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBP    = 3'd2;
  localparam logic [2:0] S_LINE   = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_VFP    = 3'd5;

  localparam logic [15:0] VS_LAST = 16'(VS_PCLKS - 1);
  localparam logic [15:0] VP_LAST = 16'(V_PORCH - 1);
  localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
  localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [8:0]  Y_LAST  = 9'(V_ACTIVE - 1);
  localparam int          BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [2:0]  state;
  logic        pclk_r;
  logic        vsync_r;
  logic        href_r;
  logic [7:0]  data_r;
  logic [15:0] cnt;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        lo_phase;
  logic [7:0]  lo_byte;
  logic [1:0]  pat_q;
  logic [15:0] solid_q;

  logic [9:0]  pix_x;
  logic [15:0] pix_val;
  int          bar_idx;

  // Pixel for the next high byte: x+1 while streaming a line, x=0 when about to start one.
  always_comb begin
    pix_x   = (state == S_LINE) ? x + 10'd1 : 10'd0;
    pix_val = 16'h0000;
    bar_idx = 32'(pix_x) / BAR_W;
    if (bar_idx > 7) bar_idx = 7;
    case (pat_q)
      2'd0: begin
        case (bar_idx)
          0:       pix_val = 16'hFFFF;
          1:       pix_val = 16'hFFE0;
          2:       pix_val = 16'h07FF;
          3:       pix_val = 16'h07E0;
          4:       pix_val = 16'hF81F;
          5:       pix_val = 16'hF800;
          6:       pix_val = 16'h001F;
          default: pix_val = 16'h0000;
        endcase
      end
      2'd1:    pix_val = {pix_x[8:4], y[7:2], pix_x[4:0]};
      2'd2:    pix_val = solid_q;
      default: pix_val = 16'(pix_x) + 16'(y) + 16'(frame_cnt);
    endcase
  end

  // Outputs only move on edges where pclk_r is 1 (pclk falling), one period per such edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pclk_r     <= 1'b0;
      vsync_r    <= 1'b0;
      href_r     <= 1'b0;
      data_r     <= 8'h00;
      cnt        <= 16'h0000;
      x          <= 10'd0;
      y          <= 9'd0;
      lo_phase   <= 1'b0;
      lo_byte    <= 8'h00;
      pat_q      <= 2'd0;
      solid_q    <= 16'h0000;
      frame_done <= 1'b0;
      frame_cnt  <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      if (state == S_IDLE) begin
        pclk_r <= 1'b0;
        if (enable) begin
          state   <= S_VSYNC;
          vsync_r <= 1'b1;
          cnt     <= 16'h0000;
          x       <= 10'd0;
          y       <= 9'd0;
          pat_q   <= pattern;
          solid_q <= solid_rgb565;
        end
      end else begin
        pclk_r <= ~pclk_r;
        if (pclk_r) begin
          cnt <= cnt + 16'd1;
          case (state)
            S_VSYNC: begin
              if (cnt == VS_LAST) begin
                state   <= S_VBP;
                vsync_r <= 1'b0;
                cnt     <= 16'h0000;
              end
            end
            S_VBP, S_HBLANK: begin
              if ((state == S_VBP && cnt == VP_LAST) || (state == S_HBLANK && cnt == HB_LAST)) begin
                state    <= S_LINE;
                href_r   <= 1'b1;
                data_r   <= pix_val[15:8];
                lo_byte  <= pix_val[7:0];
                lo_phase <= 1'b0;
                cnt      <= 16'h0000;
              end
            end
            S_LINE: begin
              if (!lo_phase) begin
                data_r   <= lo_byte;
                lo_phase <= 1'b1;
              end else if (x == X_LAST) begin
                href_r <= 1'b0;
                data_r <= 8'h00;
                x      <= 10'd0;
                cnt    <= 16'h0000;
                if (y == Y_LAST) begin
                  state <= S_VFP;
                end else begin
                  state <= S_HBLANK;
                  y     <= y + 9'd1;
                end
              end else begin
                x        <= x + 10'd1;
                data_r   <= pix_val[15:8];
                lo_byte  <= pix_val[7:0];
                lo_phase <= 1'b0;
              end
            end
            S_VFP: begin
              if (cnt == VP_LAST) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
                cnt        <= 16'h0000;
                y          <= 9'd0;
                if (enable) begin
                  state   <= S_VSYNC;
                  vsync_r <= 1'b1;
                  pat_q   <= pattern;
                  solid_q <= solid_rgb565;
                end else begin
                  state <= S_IDLE;
                end
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign cam.CAM_pclk    = pclk_r;
  assign cam.CAM_vsync   = vsync_r;
  assign cam.CAM_href    = href_r;
  assign cam.CAM_px_data = data_r;

endmodule

// File: tb/tb_cam_dvp_emulator.sv
// Directed bench: a small-geometry instance checks whole frames; a default instance checks stock timing.
module tb_cam_dvp_emulator;

  localparam int S_H  = 20;
  localparam int S_V  = 12;
  localparam int S_HB = 6;
  localparam int S_VS = 10;
  localparam int S_VP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic        s_rst, s_en, s_done;
  logic [1:0]  s_pat;
  logic [15:0] s_solid;
  logic [7:0]  s_fcnt;
  logic        d_rst, d_en, d_done;
  logic [1:0]  d_pat;
  logic [15:0] d_solid;
  logic [7:0]  d_fcnt;

  cam_dvp_emulator_if s_if ();
  cam_dvp_emulator_if d_if ();

  cam_dvp_emulator #(
    .H_ACTIVE(S_H), .V_ACTIVE(S_V), .H_BLANK(S_HB), .VS_PCLKS(S_VS), .V_PORCH(S_VP)
  ) u_small (
    .clk(clk), .rst(s_rst), .enable(s_en), .pattern(s_pat), .solid_rgb565(s_solid),
    .cam(s_if), .frame_done(s_done), .frame_cnt(s_fcnt)
  );

  cam_dvp_emulator u_dflt (
    .clk(clk), .rst(d_rst), .enable(d_en), .pattern(d_pat), .solid_rgb565(d_solid),
    .cam(d_if), .frame_done(d_done), .frame_cnt(d_fcnt)
  );

  // Expected pixel for the small instance (bar width 20/8 = 2, pixels 16..19 stay in the last bar).
  function automatic logic [15:0] model_pix(input logic [1:0] pat, input int px, input int py,
                                            input logic [15:0] solid, input logic [7:0] fc);
    logic [15:0] r;
    logic [9:0]  xv;
    logic [8:0]  yv;
    int          bar;
    xv = px[9:0];
    yv = py[8:0];
    r  = 16'h0000;
    case (pat)
      2'd0: begin
        bar = px / 2;
        if (bar > 7) bar = 7;
        case (bar)
          0: r = 16'hFFFF;
          1: r = 16'hFFE0;
          2: r = 16'h07FF;
          3: r = 16'h07E0;
          4: r = 16'hF81F;
          5: r = 16'hF800;
          6: r = 16'h001F;
          default: r = 16'h0000;
        endcase
      end
      2'd1: r = {xv[8:4], yv[7:2], xv[4:0]};
      2'd2: r = solid;
      default: r = 16'(px + py + int'(fc));
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Follows one small-instance frame from VSYNC to frame_done; applies next-frame inputs at line chg_line.
  task automatic run_frame_check(input string name, input logic [1:0] pat, input logic [15:0] solid_exp,
                                 input logic [7:0] fc_exp, input int chg_line, input logic [1:0] nxt_pat,
                                 input logic [15:0] nxt_solid, input logic nxt_en);
    int vs_clks, gap_clks, tail_clks, lines, nbytes, blank_rises, budget;
    logic prev_pclk, prev_href;
    logic [15:0] pix;
    logic [7:0] exp_b, hi_c, lo_c, rgb332;
    hi_c = 8'h00;
    lo_c = 8'h00;
    budget = 0;
    while (s_if.CAM_vsync !== 1'b1 && budget < 100) begin tick(); budget++; end
    vs_clks = 0;
    while (s_if.CAM_vsync === 1'b1 && vs_clks < 1000) begin
      vs_clks++;
      tick();
      if (vs_clks == 1) begin
        checks++;
        if (s_done !== 1'b0) $display("[TB] FAIL %s frame_done_width: got %b want 0", name, s_done);
        else passes++;
      end
    end
    checks++;
    if (vs_clks != 2 * S_VS) $display("[TB] FAIL %s vsync_clks: got %0d want %0d", name, vs_clks, 2 * S_VS);
    else passes++;
    gap_clks = 0;
    while (s_if.CAM_href !== 1'b1 && gap_clks < 1000) begin gap_clks++; tick(); end
    checks++;
    if (gap_clks != 2 * S_VP) $display("[TB] FAIL %s vbp_clks: got %0d want %0d", name, gap_clks, 2 * S_VP);
    else passes++;

    prev_pclk = s_if.CAM_pclk;
    prev_href = 1'b0;
    lines = 0; nbytes = 0; blank_rises = 0; tail_clks = 0; budget = 0;
    while (s_done !== 1'b1 && budget < 4000) begin
      if (s_if.CAM_pclk === 1'b1 && prev_pclk === 1'b0) begin
        if (s_if.CAM_href === 1'b1) begin
          pix   = model_pix(pat, nbytes / 2, lines, solid_exp, fc_exp);
          exp_b = (nbytes % 2 == 0) ? pix[15:8] : pix[7:0];
          if (pat == 2'd1 && lines == 8 && nbytes == 32) hi_c = s_if.CAM_px_data;
          if (pat == 2'd1 && lines == 8 && nbytes == 33) lo_c = s_if.CAM_px_data;
          checks++;
          if (s_if.CAM_px_data !== exp_b)
            $display("[TB] FAIL %s byte y=%0d b=%0d: got %h want %h", name, lines, nbytes, s_if.CAM_px_data, exp_b);
          else passes++;
          nbytes++;
        end else begin
          blank_rises++;
          checks++;
          if (s_if.CAM_px_data !== 8'h00) $display("[TB] FAIL %s idle_data: got %h want 00", name, s_if.CAM_px_data);
          else passes++;
        end
      end
      if (s_if.CAM_href === 1'b1 && prev_href === 1'b0) begin
        if (lines > 0) begin
          checks++;
          if (blank_rises != S_HB) $display("[TB] FAIL %s hblank: got %0d want %0d", name, blank_rises, S_HB);
          else passes++;
        end
        blank_rises = 0;
        nbytes = 0;
        if (lines == chg_line) begin s_pat = nxt_pat; s_solid = nxt_solid; s_en = nxt_en; end
      end
      if (s_if.CAM_href === 1'b0 && prev_href === 1'b1) begin
        checks++;
        if (nbytes != 2 * S_H) $display("[TB] FAIL %s line_bytes: got %0d want %0d", name, nbytes, 2 * S_H);
        else passes++;
        lines++;
      end
      if (lines == S_V && s_if.CAM_href === 1'b0) tail_clks++;
      prev_pclk = s_if.CAM_pclk;
      prev_href = s_if.CAM_href;
      tick();
      budget++;
    end
    checks++;
    if (s_done !== 1'b1) $display("[TB] FAIL %s frame_done_seen: got %b want 1", name, s_done);
    else passes++;
    checks++;
    if (lines != S_V) $display("[TB] FAIL %s lines: got %0d want %0d", name, lines, S_V);
    else passes++;
    checks++;
    if (tail_clks != 2 * S_VP) $display("[TB] FAIL %s vfp_clks: got %0d want %0d", name, tail_clks, 2 * S_VP);
    else passes++;
    checks++;
    if (s_fcnt !== fc_exp + 8'd1) $display("[TB] FAIL %s frame_cnt: got %0d want %0d", name, s_fcnt, fc_exp + 8'd1);
    else passes++;
    if (pat == 2'd1) begin
      // Pixel (16,8): R=00001 G=000010 B=10000 -> 0x0850 -> RGB332 000_000_10.
      rgb332 = {hi_c[7:5], hi_c[2:0], lo_c[4:3]};
      checks++;
      if (rgb332 !== 8'h02) $display("[TB] FAIL %s rgb332_16_8: got %h want 02", name, rgb332);
      else passes++;
    end
  endtask

  task automatic test_reset();
    s_rst = 1'b1; d_rst = 1'b1;
    s_en = 1'b0; d_en = 1'b0;
    s_pat = 2'd0; d_pat = 2'd0;
    s_solid = 16'h0000; d_solid = 16'h0000;
    #2;
    s_rst = 1'b0; d_rst = 1'b0;
    s_en = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({s_if.CAM_pclk, s_if.CAM_vsync, s_if.CAM_href, s_if.CAM_px_data, s_done} !== 12'h000)
      $display("[TB] FAIL reset_small_outputs: got %b%b%b %h %b want all 0", s_if.CAM_pclk, s_if.CAM_vsync,
               s_if.CAM_href, s_if.CAM_px_data, s_done);
    else passes++;
    checks++;
    if ({d_if.CAM_pclk, d_if.CAM_vsync, d_if.CAM_href, d_if.CAM_px_data, d_done} !== 12'h000)
      $display("[TB] FAIL reset_dflt_outputs: got %b%b%b %h %b want all 0", d_if.CAM_pclk, d_if.CAM_vsync,
               d_if.CAM_href, d_if.CAM_px_data, d_done);
    else passes++;
    checks++;
    if (s_fcnt !== 8'h00 || d_fcnt !== 8'h00) $display("[TB] FAIL reset_frame_cnt: got %0d/%0d want 0/0", s_fcnt, d_fcnt);
    else passes++;
    s_en = 1'b0;
    s_rst = 1'b1; d_rst = 1'b1;
    begin
      logic active;
      active = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (s_if.CAM_pclk !== 1'b0 || s_if.CAM_vsync !== 1'b0) active = 1'b1;
      end
      checks++;
      if (active !== 1'b0) $display("[TB] FAIL idle_wait_enable: got activity=%b want 0", active);
      else passes++;
    end
  endtask

  task automatic test_colour_bars();
    s_pat = 2'd0; s_en = 1'b1;
    run_frame_check("bars", 2'd0, 16'h0000, 8'd0, 3, 2'd2, 16'h1234, 1'b1);
  endtask

  task automatic test_solid_latch();
    run_frame_check("solid1234", 2'd2, 16'h1234, 8'd1, 3, 2'd2, 16'hABCD, 1'b1);
    run_frame_check("solidABCD", 2'd2, 16'hABCD, 8'd2, 3, 2'd1, 16'hABCD, 1'b1);
  endtask

  task automatic test_gradient();
    run_frame_check("gradient", 2'd1, 16'hABCD, 8'd3, 3, 2'd3, 16'hABCD, 1'b1);
  endtask

  task automatic test_enable_drop();
    logic active;
    run_frame_check("ramp_drop", 2'd3, 16'hABCD, 8'd4, 5, 2'd3, 16'hABCD, 1'b0);
    active = 1'b0;
    tick();
    checks++;
    if (s_done !== 1'b0) $display("[TB] FAIL drop_done_width: got %b want 0", s_done);
    else passes++;
    for (int i = 0; i < 20; i++) begin
      if (s_if.CAM_pclk !== 1'b0 || s_if.CAM_vsync !== 1'b0) active = 1'b1;
      tick();
    end
    checks++;
    if (active !== 1'b0) $display("[TB] FAIL drop_idle: got activity=%b want 0", active);
    else passes++;
  endtask

  task automatic test_reset_mid_line();
    int budget;
    logic active;
    s_pat = 2'd3; s_en = 1'b1;
    budget = 0;
    while (s_if.CAM_href !== 1'b1 && budget < 2000) begin tick(); budget++; end
    checks++;
    if (s_if.CAM_href !== 1'b1) $display("[TB] FAIL midreset_href_reached: got %b want 1", s_if.CAM_href);
    else passes++;
    for (int i = 0; i < 5; i++) tick();
    s_rst = 1'b0;
    #1;
    checks++;
    if ({s_if.CAM_pclk, s_if.CAM_vsync, s_if.CAM_href, s_if.CAM_px_data, s_done} !== 12'h000)
      $display("[TB] FAIL midreset_outputs: got %b%b%b %h %b want all 0", s_if.CAM_pclk, s_if.CAM_vsync,
               s_if.CAM_href, s_if.CAM_px_data, s_done);
    else passes++;
    checks++;
    if (s_fcnt !== 8'h00) $display("[TB] FAIL midreset_frame_cnt: got %0d want 0", s_fcnt);
    else passes++;
    s_en = 1'b0;
    #20;
    s_rst = 1'b1;
    active = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_if.CAM_pclk !== 1'b0 || s_if.CAM_vsync !== 1'b0) active = 1'b1;
    end
    checks++;
    if (active !== 1'b0) $display("[TB] FAIL midreset_waits_enable: got activity=%b want 0", active);
    else passes++;
  endtask

  task automatic test_default_timing();
    int budget, vs_clks, gap_clks, nb;
    logic prev_pclk;
    logic [7:0] cap [82];
    for (int i = 0; i < 82; i++) cap[i] = 8'hxx;
    d_pat = 2'd0; d_en = 1'b1;
    budget = 0;
    while (d_if.CAM_vsync !== 1'b1 && budget < 100) begin tick(); budget++; end
    vs_clks = 0;
    while (d_if.CAM_vsync === 1'b1 && vs_clks < 5000) begin vs_clks++; tick(); end
    checks++;
    if (vs_clks != 3136) $display("[TB] FAIL dflt_vsync_clks: got %0d want 3136", vs_clks);
    else passes++;
    gap_clks = 0;
    while (d_if.CAM_href !== 1'b1 && gap_clks < 3000) begin gap_clks++; tick(); end
    checks++;
    if (gap_clks != 1568) $display("[TB] FAIL dflt_vbp_clks: got %0d want 1568", gap_clks);
    else passes++;
    nb = 0; budget = 0;
    prev_pclk = d_if.CAM_pclk;
    while (nb < 82 && budget < 1000) begin
      if (d_if.CAM_pclk === 1'b1 && prev_pclk === 1'b0 && d_if.CAM_href === 1'b1) begin
        cap[nb] = d_if.CAM_px_data;
        nb++;
      end
      prev_pclk = d_if.CAM_pclk;
      tick();
      budget++;
    end
    checks++;
    if ({cap[0], cap[1]} !== 16'hFFFF) $display("[TB] FAIL dflt_pixel0: got %h%h want FFFF", cap[0], cap[1]);
    else passes++;
    checks++;
    if ({cap[78], cap[79]} !== 16'hFFFF) $display("[TB] FAIL dflt_pixel39: got %h%h want FFFF", cap[78], cap[79]);
    else passes++;
    checks++;
    if ({cap[80], cap[81]} !== 16'hFFE0) $display("[TB] FAIL dflt_pixel40: got %h%h want FFE0", cap[80], cap[81]);
    else passes++;
    checks++;
    if (d_if.CAM_href !== 1'b1) $display("[TB] FAIL dflt_in_line: got href=%b want 1", d_if.CAM_href);
    else passes++;
    d_rst = 1'b0;
    #1;
    checks++;
    if ({d_if.CAM_pclk, d_if.CAM_vsync, d_if.CAM_href, d_if.CAM_px_data, d_done, d_fcnt} !== 20'h00000)
      $display("[TB] FAIL dflt_midreset: got %b%b%b %h %b %0d want all 0", d_if.CAM_pclk, d_if.CAM_vsync,
               d_if.CAM_href, d_if.CAM_px_data, d_done, d_fcnt);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_colour_bars();
    test_solid_latch();
    test_gradient();
    test_enable_drop();
    test_reset_mid_line();
    test_default_timing();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cam_dvp_emulator.md
CAM_DVP_EMULATOR -- requirements
Module: cam_dvp_emulator

Interface
REQ-001 Parameter H_ACTIVE, default 320: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 240: active lines per frame.
REQ-003 Parameter H_BLANK, default 144: PCLK periods with HREF low between lines.
REQ-004 Parameter VS_PCLKS, default 1568: PCLK periods with VSYNC high.
REQ-005 Parameter V_PORCH, default 784: PCLK periods of idle between VSYNC fall and the first HREF, and after the last line.
REQ-006 clk  in  1  system clock; all flops on rising edge.
REQ-007 rst  in  1  reset; asynchronous assert, active-low (0 = reset).
REQ-008 enable  in  1  start and continue frame generation.
REQ-009 pattern  in  2  0 colour bars, 1 XY gradient, 2 solid, 3 frame-scrolling ramp.
REQ-010 solid_rgb565  in  16  colour used when pattern=2.
REQ-011 CAM_pclk  out  1  pixel clock, clk/2.
REQ-012 CAM_vsync  out  1  frame sync, active high.
REQ-013 CAM_href  out  1  line valid, active high.
REQ-014 CAM_px_data  out  8  RGB565 byte stream.
REQ-015 frame_done  out  1  one-clk pulse at end of each frame.
REQ-016 frame_cnt  out  8  completed frames, wraps 255->0.

Function
REQ-017 CAM_pclk SHALL toggle every clk while state is not IDLE; it SHALL be held 0 in IDLE.
REQ-018 CAM_vsync, CAM_href, and CAM_px_data SHALL change only on the clk edge that drives CAM_pclk 1->0, giving a receiver sampling on CAM_pclk rising edge one full clk of setup.
REQ-019 All timing counts SHALL be in PCLK periods; one PCLK period = 2 clk.
REQ-020 FSM states SHALL be IDLE, VSYNC, VBP, LINE, HBLANK, VFP.
REQ-021 IDLE->VSYNC SHALL occur when enable=1 is sampled in IDLE; enable SHALL be ignored in all other states.
REQ-022 In VSYNC, CAM_vsync=1 for VS_PCLKS periods, then ->VBP.
REQ-023 In VBP, all sync outputs SHALL be 0 for V_PORCH periods, then ->LINE with line index y=0.
REQ-024 In LINE, CAM_href=1 for exactly 2*H_ACTIVE periods, with two bytes per pixel.
REQ-025 Byte order SHALL be high byte {R[4:0],G[5:3]} first, then low byte {G[2:0],B[4:0]}.
REQ-026 After LINE: if y<V_ACTIVE-1, the FSM SHALL go ->HBLANK (H_BLANK periods, href=0), increment y, then ->LINE; else ->VFP.
REQ-027 In VFP, outputs SHALL be 0 for V_PORCH periods, then frame_done SHALL pulse and frame_cnt SHALL increment.
REQ-028 After VFP, the FSM SHALL go ->VSYNC if enable=1, else ->IDLE.
REQ-029 Deasserting enable mid-frame SHALL NOT truncate the frame.
REQ-030 CAM_px_data SHALL be 0 whenever CAM_href=0.
REQ-031 Pattern 0 SHALL produce 8 equal vertical bars of width H_ACTIVE/8 (integer divide; leftover pixels use the last bar), in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-032 Pattern 1 SHALL produce R=x[8:4], G=y[7:2], B=x[4:0], with x,y truncated to field width.
REQ-033 Pattern 2 SHALL output solid_rgb565, latched at VSYNC entry and constant for the frame.
REQ-034 Pattern 3 SHALL output the 16-bit value (x+y+frame_cnt) mod 2^16.
REQ-035 pattern SHALL be latched at VSYNC entry; changes mid-frame SHALL take effect next frame.
REQ-036 Pixel counter x (10 bits) and line counter y (9 bits) SHALL reset to 0 at each line and frame start respectively.

Reset
REQ-037 While rst=0, the block SHALL be in IDLE with CAM_pclk=0, CAM_vsync=0, CAM_href=0, CAM_px_data=0, frame_done=0, frame_cnt=0, and all counters 0.
REQ-038 rst asserted mid-frame SHALL abort immediately to these values.
REQ-039 After rst release, the block SHALL wait for enable per REQ-021.

Verification
REQ-040 Reset then enable=1, pattern=0 (defaults) -> vsync high 3136 clk; first href rises 1568 clk after vsync falls; first bytes FF,FF; byte 80 (pixel 40) = FF,E0.
REQ-041 Full frame count -> exactly 240 href pulses of 640 bytes each, 144-period gaps; frame_done one clk wide; frame_cnt=1.
REQ-042 pattern=2, solid_rgb565=0x1234, change to 0xABCD mid-frame -> all bytes 12,34 this frame, AB,CD next frame.
REQ-043 enable dropped during line 100 -> frame completes all 240 lines, then IDLE with CAM_pclk=0.
REQ-044 rst=0 during a LINE byte -> all outputs 0 immediately; frame_cnt=0.
REQ-045 Drive the team's Capturador_DD with this block at pattern=1 -> captured RGB332 at (x=16,y=8) equals {R[4:2],G[5:3],B[4:3]} of the pixel generated at that position.
